// File: rtl/ad5667_pkg.sv
// -----------------------------------------------------------------------------
// ad5667_pkg
// Shared constants and types for the AD5667 DAC scheduler:
//   - AD5667 command codes and channel selectors (command byte = {2'b00, cmd, ch})
//   - 7-bit slave base address (A1:A0 appended by the top-level parameter)
//   - scheduler state encoding and request kinds
//   - cmd_byte(): command byte for a given request kind
// -----------------------------------------------------------------------------
package ad5667_pkg;

   localparam logic [2:0] CMD_WRITE          = 3'b000;
   localparam logic [2:0] CMD_UPDATE         = 3'b001;
   localparam logic [2:0] CMD_WRITE_UPD_ALL  = 3'b010;
   localparam logic [2:0] CMD_WRITE_UPDATE   = 3'b011;
   localparam logic [2:0] CMD_POWER          = 3'b100;
   localparam logic [2:0] CMD_RESET          = 3'b101;
   localparam logic [2:0] CMD_LDAC           = 3'b110;
   localparam logic [2:0] CMD_REFERENCE      = 3'b111;

   localparam logic [2:0] CH_A  = 3'b000;
   localparam logic [2:0] CH_B  = 3'b001;
   localparam logic [2:0] CH_AB = 3'b111;

   localparam logic [4:0] BASE_ADDR = 5'b00011;

   // Data bytes of the reference command: 0x00 0x01 switches the internal reference on.
   localparam logic [15:0] REF_ON_PAYLOAD = 16'h0001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RETRY = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REQ_A   = 2'd0,
      REQ_B   = 2'd1,
      REQ_REF = 2'd2
   } req_e;

   function automatic logic [7:0] cmd_byte(input req_e kind);
      case (kind)
         REQ_A:   cmd_byte = {2'b00, CMD_WRITE_UPDATE, CH_A};
         REQ_B:   cmd_byte = {2'b00, CMD_WRITE_UPDATE, CH_B};
         default: cmd_byte = {2'b00, CMD_REFERENCE, CH_A};
      endcase
   endfunction

endpackage

// File: rtl/ad5667_dac_scheduler_if.sv
// -----------------------------------------------------------------------------
// ad5667_dac_scheduler_if
// Byte-level request/response channel between the scheduler and the I2C master.
//   valid/ready : byte handshake (byte accepted when both high)
//   start/stop  : generate START before / STOP after this byte (qualified by valid)
//   data        : byte to transmit
//   done        : 1-cycle pulse, the accepted byte has finished on the bus
//   nack        : valid with done, the slave did not acknowledge
// The scheduler originates the byte stream and uses the master modport; the
// I2C bus master sits on the slave modport of this channel.
// -----------------------------------------------------------------------------
interface ad5667_dac_scheduler_if;
   logic       valid;
   logic       ready;
   logic       start;
   logic       stop;
   logic [7:0] data;
   logic       done;
   logic       nack;

   modport master (
      output valid, start, stop, data,
      input  ready, done, nack
   );

   modport slave (
      input  valid, start, stop, data,
      output ready, done, nack
   );
endinterface

// File: rtl/ad5667_req_arbiter.sv
// -----------------------------------------------------------------------------
// ad5667_req_arbiter
// Holds the per-channel target codes, dirty bits and shadow-changed flags, the
// round-robin pointer, and the payload snapshot taken at grant.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_dac_a/_wr         channel A target code and 1-cycle write strobe
//   i_dac_b/_wr         channel B target code and 1-cycle write strobe
//   i_ref_pending       reference-on command still owed (highest priority)
//   i_grant             scheduler accepts the current pick (IDLE only)
//   i_retire            granted request has finished (completed or dropped)
//   o_req_valid         something is waiting to be sent
//   o_dirty             at least one channel is dirty
//   o_kind              kind of the granted (in-flight) request
//   o_snap              16-bit payload of the granted request
// -----------------------------------------------------------------------------
module ad5667_req_arbiter
   import ad5667_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_dac_a,
   input  logic        i_dac_a_wr,
   input  logic [15:0] i_dac_b,
   input  logic        i_dac_b_wr,
   input  logic        i_ref_pending,
   input  logic        i_grant,
   input  logic        i_retire,
   output logic        o_req_valid,
   output logic        o_dirty,
   output req_e        o_kind,
   output logic [15:0] o_snap
);

   logic        r_dirty_a, r_dirty_b;
   logic        r_shadow_a, r_shadow_b;
   logic        r_ptr_b;
   req_e        r_kind;
   logic [15:0] r_tgt_a, r_tgt_b, r_snap;
   req_e        w_pick;

   always_comb begin
      w_pick = REQ_A;
      if (i_ref_pending)
         w_pick = REQ_REF;
      else if (r_dirty_a && r_dirty_b)
         w_pick = r_ptr_b ? REQ_B : REQ_A;
      else if (r_dirty_b)
         w_pick = REQ_B;
   end

   // The shadow flag records any write since the channel was last granted.
   // A write in the grant cycle itself is not in the snapshot, so it sets the
   // flag too; retiring a channel clears dirty only when the flag is clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dirty_a  <= 1'b0;
         r_dirty_b  <= 1'b0;
         r_shadow_a <= 1'b0;
         r_shadow_b <= 1'b0;
         r_ptr_b    <= 1'b0;
         r_kind     <= REQ_A;
      end else begin
         if (i_grant) begin
            r_kind <= w_pick;
            if (w_pick != REQ_REF && r_dirty_a && r_dirty_b)
               r_ptr_b <= ~r_ptr_b;
         end

         if (i_dac_a_wr) begin
            r_dirty_a  <= 1'b1;
            r_shadow_a <= 1'b1;
         end else begin
            if (i_grant && w_pick == REQ_A)
               r_shadow_a <= 1'b0;
            if (i_retire && r_kind == REQ_A && !r_shadow_a)
               r_dirty_a <= 1'b0;
         end

         if (i_dac_b_wr) begin
            r_dirty_b  <= 1'b1;
            r_shadow_b <= 1'b1;
         end else begin
            if (i_grant && w_pick == REQ_B)
               r_shadow_b <= 1'b0;
            if (i_retire && r_kind == REQ_B && !r_shadow_b)
               r_dirty_b <= 1'b0;
         end
      end
   end

   // Data registers carry no reset; they are only observed once a dirty bit
   // or a grant qualifies them.
   always_ff @(posedge i_clk) begin
      if (i_dac_a_wr)
         r_tgt_a <= i_dac_a;
      if (i_dac_b_wr)
         r_tgt_b <= i_dac_b;
      if (i_grant) begin
         case (w_pick)
            REQ_A:   r_snap <= r_tgt_a;
            REQ_B:   r_snap <= r_tgt_b;
            default: r_snap <= REF_ON_PAYLOAD;
         endcase
      end
   end

   assign o_dirty     = r_dirty_a | r_dirty_b;
   assign o_req_valid = i_ref_pending | r_dirty_a | r_dirty_b;
   assign o_kind      = r_kind;
   assign o_snap      = r_snap;

endmodule

// File: rtl/ad5667_dac_scheduler.sv
// -----------------------------------------------------------------------------
// ad5667_dac_scheduler
// Keeps the two AD5667 outputs equal to the firmware target codes by issuing
// 4-byte write-and-update transactions through a byte-level I2C master, with
// an optional one-time internal-reference-on command after reset.
// Parameters:
//   ADDR_SEL   A1:A0 address pins; slave address {5'b00011, ADDR_SEL}
//   INT_REF    issue the reference-on command once after reset
//   MAX_RETRY  re-attempts of a NACKed transaction before it is dropped
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   dac_a_i/dac_a_wr_i  channel A target code and write strobe
//   dac_b_i/dac_b_wr_i  channel B target code and write strobe
//   i2c                 byte channel to the I2C master (master modport)
//   dac_a_o, dac_b_o    last code successfully written to each channel
//   busy_o              transaction in flight or anything pending
//   err_o               sticky: a transaction was dropped after retries
// -----------------------------------------------------------------------------
module ad5667_dac_scheduler
   import ad5667_pkg::*;
#(
   parameter logic [1:0] ADDR_SEL  = 2'b00,
   parameter bit         INT_REF   = 1'b1,
   parameter int         MAX_RETRY = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [15:0]                   dac_a_i,
   input  logic                          dac_a_wr_i,
   input  logic [15:0]                   dac_b_i,
   input  logic                          dac_b_wr_i,
   ad5667_dac_scheduler_if.master        i2c,
   output logic [15:0]                   dac_a_o,
   output logic [15:0]                   dac_b_o,
   output logic                          busy_o,
   output logic                          err_o
);

   localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

   state_e               r_state, w_state_nxt;
   logic [1:0]           r_idx, w_idx_nxt;
   logic [RETRY_W-1:0]   r_retry, w_retry_nxt;
   logic                 r_ref_pending;
   logic                 w_grant, w_complete, w_drop, w_retire;
   logic                 w_req_valid, w_dirty;
   req_e                 w_kind;
   logic [15:0]          w_snap;

   ad5667_req_arbiter u_arb (
      .i_clk         (clk_i),
      .i_rst         (rst_i),
      .i_dac_a       (dac_a_i),
      .i_dac_a_wr    (dac_a_wr_i),
      .i_dac_b       (dac_b_i),
      .i_dac_b_wr    (dac_b_wr_i),
      .i_ref_pending (r_ref_pending),
      .i_grant       (w_grant),
      .i_retire      (w_retire),
      .o_req_valid   (w_req_valid),
      .o_dirty       (w_dirty),
      .o_kind        (w_kind),
      .o_snap        (w_snap)
   );

   assign w_retire = w_complete | w_drop;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_retry_nxt = r_retry;
      w_grant     = 1'b0;
      w_complete  = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_valid) begin
               w_grant     = 1'b1;
               w_idx_nxt   = 2'd0;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i2c.ready)
               w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i2c.done) begin
               if (i2c.nack)
                  w_state_nxt = ST_RETRY;
               else if (r_idx == 2'd3) begin
                  w_complete  = 1'b1;
                  w_retry_nxt = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = ST_SEND;
               end
            end
         end
         ST_RETRY: begin
            // The master has already issued STOP; restart from the address byte.
            if (int'(r_retry) < MAX_RETRY) begin
               w_retry_nxt = r_retry + RETRY_W'(1);
               w_idx_nxt   = 2'd0;
               w_state_nxt = ST_SEND;
            end else begin
               w_drop      = 1'b1;
               w_retry_nxt = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Byte fields are forced to zero outside SEND so nothing stale is visible.
   always_comb begin
      i2c.valid = 1'b0;
      i2c.start = 1'b0;
      i2c.stop  = 1'b0;
      i2c.data  = 8'h00;
      if (r_state == ST_SEND) begin
         i2c.valid = 1'b1;
         i2c.start = (r_idx == 2'd0);
         i2c.stop  = (r_idx == 2'd3);
         case (r_idx)
            2'd0:    i2c.data = {BASE_ADDR, ADDR_SEL, 1'b0};
            2'd1:    i2c.data = cmd_byte(w_kind);
            2'd2:    i2c.data = w_snap[15:8];
            default: i2c.data = w_snap[7:0];
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_idx         <= 2'd0;
         r_retry       <= '0;
         r_ref_pending <= INT_REF;
         err_o         <= 1'b0;
         dac_a_o       <= 16'h0000;
         dac_b_o       <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_retry <= w_retry_nxt;
         if (w_drop)
            err_o <= 1'b1;
         if (w_retire && w_kind == REQ_REF)
            r_ref_pending <= 1'b0;
         if (w_complete && w_kind == REQ_A)
            dac_a_o <= w_snap;
         if (w_complete && w_kind == REQ_B)
            dac_b_o <= w_snap;
      end
   end

   assign busy_o = (r_state != ST_IDLE) | w_dirty | r_ref_pending;

endmodule

// File: tb/tb_ad5667_dac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ad5667_dac_scheduler
// Bench for ad5667_dac_scheduler (ADDR_SEL=00, INT_REF=1, MAX_RETRY=3).
// A responder plays the I2C master (always ready, done 3 cycles after a byte
// is accepted, NACK on address bytes on request) and feeds a small AD5667
// behavioural model (VOUTA/VOUTB). Expected bytes are queued when stimulus is
// driven and compared as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_ad5667_dac_scheduler;

   typedef struct packed {
      logic       start;
      logic       stop;
      logic [7:0] data;
   } ibyte_t;

   typedef struct {
      bit          wa;
      logic [15:0] a;
      bit          wb;
      logic [15:0] b;
      bit          b_first;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dac_a = 16'h0000;
   logic [15:0] dac_b = 16'h0000;
   logic        wr_a = 1'b0;
   logic        wr_b = 1'b0;
   logic [15:0] dac_a_o, dac_b_o;
   logic        busy, err;

   int total = 0;
   int bad   = 0;

   ibyte_t exp_q[$];
   int     byte_cnt    = 0;
   int     nack_budget = 0;
   bit     nack_always = 1'b0;

   // AD5667 model state
   logic [7:0]  m_buf [4];
   int          m_idx = 0;
   logic [15:0] vout_a = 16'h0000;
   logic [15:0] vout_b = 16'h0000;

   always #5 clk = ~clk;

   ad5667_dac_scheduler_if i2c ();

   ad5667_dac_scheduler #(
      .ADDR_SEL  (2'b00),
      .INT_REF   (1'b1),
      .MAX_RETRY (3)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .dac_a_i    (dac_a),
      .dac_a_wr_i (wr_a),
      .dac_b_i    (dac_b),
      .dac_b_wr_i (wr_b),
      .i2c        (i2c),
      .dac_a_o    (dac_a_o),
      .dac_b_o    (dac_b_o),
      .busy_o     (busy),
      .err_o      (err)
   );

   // I2C master stand-in plus AD5667 model
   initial begin
      int     pend;
      bit     nack_this;
      ibyte_t got, want;
      pend      = 0;
      nack_this = 1'b0;
      i2c.ready = 1'b1;
      i2c.done  = 1'b0;
      i2c.nack  = 1'b0;
      forever begin
         @(negedge clk);
         i2c.done = 1'b0;
         i2c.nack = 1'b0;
         if (rst) begin
            pend = 0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               i2c.done = 1'b1;
               i2c.nack = nack_this;
            end
         end else if (i2c.valid && i2c.ready) begin
            got = {i2c.start, i2c.stop, i2c.data};
            byte_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL i2c_byte got start=%b stop=%b data=%h required=no byte",
                        got.start, got.stop, got.data);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("FAIL i2c_byte got start=%b stop=%b data=%h required start=%b stop=%b data=%h",
                           got.start, got.stop, got.data, want.start, want.stop, want.data);
               end
            end
            nack_this = 1'b0;
            if (got.start) begin
               m_idx = 0;
               if (nack_always)
                  nack_this = 1'b1;
               else if (nack_budget > 0) begin
                  nack_this = 1'b1;
                  nack_budget--;
               end
            end
            if (!nack_this && m_idx < 4) begin
               m_buf[m_idx] = got.data;
               m_idx++;
               if (got.stop && m_idx == 4 && m_buf[0] == 8'h18 && m_buf[1][7:3] == 5'b00011) begin
                  if (m_buf[1][2:0] == 3'b000)
                     vout_a = {m_buf[2], m_buf[3]};
                  else if (m_buf[1][2:0] == 3'b001)
                     vout_b = {m_buf[2], m_buf[3]};
               end
            end
            pend = 3;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic push_txn(input logic [7:0] cmd, input logic [15:0] payload);
      exp_q.push_back({1'b1, 1'b0, 8'h18});
      exp_q.push_back({1'b0, 1'b0, cmd});
      exp_q.push_back({1'b0, 1'b0, payload[15:8]});
      exp_q.push_back({1'b0, 1'b1, payload[7:0]});
   endtask

   task automatic push_addr_only();
      exp_q.push_back({1'b1, 1'b0, 8'h18});
   endtask

   task automatic strobe(input bit wa, input logic [15:0] a, input bit wb, input logic [15:0] b);
      @(negedge clk);
      wr_a  = wa;
      dac_a = a;
      wr_b  = wb;
      dac_b = b;
      @(negedge clk);
      wr_a = 1'b0;
      wr_b = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL %s_idle_timeout got busy=1 required busy=0", name);
      end
   endtask

   task automatic wait_bytes(input int target, input string name);
      int n;
      n = 0;
      while (byte_cnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (byte_cnt < target) begin
         total++;
         bad++;
         $display("FAIL %s_byte_timeout got=%0d required=%0d", name, byte_cnt, target);
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   base;
      int   n;

      //             wa    a        wb    b        bfirst exp_a    exp_b
      vecs[0] = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 16'h1111, 16'h2222};
      vecs[2] = '{1'b1, 16'h3333, 1'b1, 16'h4444, 1'b1, 16'h3333, 16'h4444};
      vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'h8001, 1'b0, 16'h3333, 16'h8001};
      vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 16'h8001};
      vecs[5] = '{1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};

      // Reset state, then the reference-on command
      repeat (3) @(negedge clk);
      check16("rst_valid", {15'd0, i2c.valid}, 16'd0);
      check16("rst_start_stop", {14'd0, i2c.start, i2c.stop}, 16'd0);
      check16("rst_data", {8'd0, i2c.data}, 16'd0);
      check16("rst_dac_a", dac_a_o, 16'h0000);
      check16("rst_dac_b", dac_b_o, 16'h0000);
      check16("rst_err", {15'd0, err}, 16'd0);
      check16("rst_busy_ref_pending", {15'd0, busy}, 16'd1);
      push_txn(8'h38, 16'h0001);
      rst = 1'b0;
      wait_idle("ref");
      check16("ref_dac_a", dac_a_o, 16'h0000);
      check16("ref_dac_b", dac_b_o, 16'h0000);
      check16("ref_busy", {15'd0, busy}, 16'd0);

      // Table-driven single and simultaneous writes
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].b_first) begin
            if (vecs[i].wb) push_txn(8'h19, vecs[i].b);
            if (vecs[i].wa) push_txn(8'h18, vecs[i].a);
         end else begin
            if (vecs[i].wa) push_txn(8'h18, vecs[i].a);
            if (vecs[i].wb) push_txn(8'h19, vecs[i].b);
         end
         strobe(vecs[i].wa, vecs[i].a, vecs[i].wb, vecs[i].b);
         wait_idle($sformatf("vec%0d", i));
         check16($sformatf("vec%0d_dac_a", i), dac_a_o, vecs[i].exp_a);
         check16($sformatf("vec%0d_dac_b", i), dac_b_o, vecs[i].exp_b);
         check16($sformatf("vec%0d_vout_a", i), vout_a, vecs[i].exp_a);
         check16($sformatf("vec%0d_vout_b", i), vout_b, vecs[i].exp_b);
         check16($sformatf("vec%0d_err", i), {15'd0, err}, 16'd0);
      end

      // New B value strobed while byte 2 of the previous one is in flight
      base = byte_cnt;
      push_txn(8'h19, 16'h0100);
      push_txn(8'h19, 16'h0200);
      strobe(1'b0, 16'h0000, 1'b1, 16'h0100);
      wait_bytes(base + 3, "shadow");
      strobe(1'b0, 16'h0000, 1'b1, 16'h0200);
      n = 0;
      while (dac_b_o == 16'hFFFF && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check16("shadow_first_dac_b", dac_b_o, 16'h0100);
      wait_idle("shadow");
      check16("shadow_final_dac_b", dac_b_o, 16'h0200);
      check16("shadow_vout_b", vout_b, 16'h0200);

      // Two NACKs on the address byte, then success
      nack_budget = 2;
      push_addr_only();
      push_addr_only();
      push_txn(8'h18, 16'h5A5A);
      strobe(1'b1, 16'h5A5A, 1'b0, 16'h0000);
      wait_idle("nack2");
      check16("nack2_dac_a", dac_a_o, 16'h5A5A);
      check16("nack2_vout_a", vout_a, 16'h5A5A);
      check16("nack2_err", {15'd0, err}, 16'd0);

      // Permanent NACK: four attempts, then dropped
      nack_always = 1'b1;
      repeat (4) push_addr_only();
      strobe(1'b1, 16'h1234, 1'b0, 16'h0000);
      wait_idle("nack_all");
      nack_always = 1'b0;
      check16("nack_all_err", {15'd0, err}, 16'd1);
      check16("nack_all_dac_a", dac_a_o, 16'h5A5A);
      check16("nack_all_busy", {15'd0, busy}, 16'd0);

      // Reset while waiting on byte 2
      base = byte_cnt;
      exp_q.push_back({1'b1, 1'b0, 8'h18});
      exp_q.push_back({1'b0, 1'b0, 8'h18});
      exp_q.push_back({1'b0, 1'b0, 8'h77});
      strobe(1'b1, 16'h7777, 1'b0, 16'h0000);
      wait_bytes(base + 3, "midrst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check16("midrst_valid", {15'd0, i2c.valid}, 16'd0);
      check16("midrst_start_stop_data", {6'd0, i2c.start, i2c.stop, i2c.data}, 16'd0);
      check16("midrst_dac_a", dac_a_o, 16'h0000);
      check16("midrst_dac_b", dac_b_o, 16'h0000);
      check16("midrst_err", {15'd0, err}, 16'd0);
      @(negedge clk);
      push_txn(8'h38, 16'h0001);
      rst = 1'b0;
      wait_idle("midrst_ref");
      check16("midrst_ref_dac_a", dac_a_o, 16'h0000);
      check16("midrst_ref_busy", {15'd0, busy}, 16'd0);

      repeat (5) @(negedge clk);
      check16("scoreboard_left", 16'(exp_q.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
